// File: rtl/fp16_mul.sv
// IEEE 754 binary16 multiplier, round-to-nearest-even, one-cycle latency.
// Ports: clk, rst_n (sync, active-low), input1/input2 operands, result product.
module fp16_mul (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] input1,
  input  logic [15:0] input2,
  output logic [15:0] result
);

  logic [15:0] result_q, result_d;

  logic        sa, sb, sr;
  logic [4:0]  ea, eb, ee_a, ee_b;
  logic [9:0]  fa, fb;
  logic [10:0] ma, mb;
  logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  logic [21:0] prod, norm, kept;
  logic [4:0]  lz;
  logic signed [7:0] e_s;
  logic [5:0]  sh;
  logic [32:0] wide;
  logic [4:0]  exp_f;
  logic [9:0]  mant;
  logic        guard, sticky, rnd;
  logic [14:0] sum;

  assign sa = input1[15];
  assign sb = input2[15];
  assign sr = sa ^ sb;
  assign ea = input1[14:10];
  assign eb = input2[14:10];
  assign fa = input1[9:0];
  assign fb = input2[9:0];

  // Subnormals have no hidden bit and share exponent 1 with the minimum normal.
  assign ma   = {|ea, fa};
  assign mb   = {|eb, fb};
  assign ee_a = (ea == 5'd0) ? 5'd1 : ea;
  assign ee_b = (eb == 5'd0) ? 5'd1 : eb;

  assign nan_a  = (ea == 5'h1F) && (fa != 10'd0);
  assign nan_b  = (eb == 5'h1F) && (fb != 10'd0);
  assign inf_a  = (ea == 5'h1F) && (fa == 10'd0);
  assign inf_b  = (eb == 5'h1F) && (fb == 10'd0);
  assign zero_a = (ea == 5'd0) && (fa == 10'd0);
  assign zero_b = (eb == 5'd0) && (fb == 10'd0);

  assign prod = 22'(ma) * 22'(mb);

  // Leading-zero count: ascending scan, the highest set bit wins.
  always_comb begin
    lz = 5'd21;
    for (int i = 0; i < 22; i++) begin
      if (prod[i]) lz = 5'(21 - i);
    end
  end

  // Leading one moved to bit 21; exponent tracks the shift.
  assign norm = prod << lz;
  assign e_s  = $signed({3'b0, ee_a}) + $signed({3'b0, ee_b})
              - 8'sd14 - $signed({3'b0, lz});

  always_comb begin
    sh    = 6'd0;
    exp_f = e_s[4:0];
    if (e_s < 8'sd1) begin
      exp_f = 5'd0;
      sh    = (e_s < -8'sd31) ? 6'd32 : 6'(8'sd1 - e_s);
    end
  end

  // Extra low bits keep everything shifted out visible to sticky.
  assign wide   = {norm, 11'b0} >> sh;
  assign kept   = wide[32:11];
  assign mant   = kept[20:11];
  assign guard  = kept[10];
  assign sticky = (|kept[9:0]) | (|wide[10:0]);
  assign rnd    = guard & (sticky | mant[0]);

  // Mantissa carry ripples into the exponent field, including subnormal
  // to min-normal and max-normal to infinity.
  assign sum = {exp_f, mant} + 15'(rnd);

  always_comb begin
    result_d = {sr, sum};
    if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b))
      result_d = 16'h7E00;
    else if (inf_a || inf_b)
      result_d = {sr, 5'h1F, 10'h0};
    else if (zero_a || zero_b)
      result_d = {sr, 15'h0};
    else if (e_s > 8'sd30)
      result_d = {sr, 5'h1F, 10'h0};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) result_q <= 16'h0000;
    else        result_q <= result_d;
  end

  assign result = result_q;

endmodule

// File: tb/tb_fp16_mul.sv
// Self-checking bench for fp16_mul: directed vectors plus random
// operands against a real-arithmetic reference model.
module tb_fp16_mul;

  logic        clk;
  logic        rst_n;
  logic [15:0] input1, input2;
  logic [15:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  fp16_mul u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .input1 (input1),
    .input2 (input2),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic real pow2(input int k);
    real r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real val(input logic [15:0] h);
    int e = int'(h[14:10]);
    int f = int'(h[9:0]);
    if (e == 0) return real'(f) * pow2(-24);
    return real'(1024 + f) * pow2(e - 25);
  endfunction

  function automatic logic [15:0] ref_mul(input logic [15:0] a,
                                          input logic [15:0] b);
    logic s = a[15] ^ b[15];
    logic an = (a[14:10] == 5'h1F) && (a[9:0] != 0);
    logic bn = (b[14:10] == 5'h1F) && (b[9:0] != 0);
    logic ai = (a[14:10] == 5'h1F) && (a[9:0] == 0);
    logic bi = (b[14:10] == 5'h1F) && (b[9:0] == 0);
    logic az = (a[14:0] == 0);
    logic bz = (b[14:0] == 0);
    real x, n, fl;
    int e, bits;
    if (an || bn || (ai && bz) || (az && bi)) return 16'h7E00;
    if (ai || bi) return {s, 15'h7C00};
    if (az || bz) return {s, 15'h0};
    // Product of two fp16 values is exact in double precision.
    x = val(a) * val(b);
    if (x >= 65520.0) return {s, 15'h7C00};
    e = 0;
    n = x;
    while (n >= 2.0) begin n = n / 2.0; e++; end
    while (n < 1.0)  begin n = n * 2.0; e--; end
    if (e < -14) e = -14;
    n = x / pow2(e - 10);
    fl = $floor(n);
    if ((n - fl > 0.5) ||
        ((n - fl == 0.5) && ((longint'(fl) % 2) == 1)))
      fl = fl + 1.0;
    bits = (e + 14) * 1024 + int'(fl);
    return {s, 15'(bits)};
  endfunction

  // Drive on the falling edge, check just after the next rising edge.
  task automatic apply(input string tag, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] exp);
    @(negedge clk);
    input1 = a;
    input2 = b;
    @(posedge clk);
    #1;
    chk(tag, result, exp);
  endtask

  function automatic logic [15:0] rand_op();
    logic [15:0] v = 16'($urandom);
    case ($urandom_range(0, 7))
      0: v[14:10] = 5'h00;
      1: v[14:10] = 5'h1F;
      2: v[14:0]  = 15'h0;
      3: v[14:10] = 5'($urandom_range(1, 6));
      4: v[14:10] = 5'($urandom_range(24, 30));
      5: v[14:10] = 5'($urandom_range(12, 18));
      default: ;
    endcase
    return v;
  endfunction

  initial begin
    logic [15:0] a, b;
    rst_n  = 1'b0;
    input1 = 16'h3C00;
    input2 = 16'h4000;
    @(posedge clk);
    #1;
    chk("reset", result, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    apply("basic1", 16'h3C00, 16'h4000, 16'h4000);
    apply("basic2", 16'h3E00, 16'h3E00, 16'h4080);
    apply("basic3", 16'hC000, 16'h3800, 16'hBC00);
    apply("rnd_dn", 16'h3C01, 16'h3C01, 16'h3C02);
    apply("tie0",   16'h0001, 16'h3800, 16'h0000);
    apply("tie2",   16'h0003, 16'h3800, 16'h0002);
    apply("sub1",   16'h0001, 16'h3C00, 16'h0001);
    apply("sub2",   16'h0200, 16'h3800, 16'h0100);
    apply("sub3",   16'h0400, 16'h3800, 16'h0200);
    apply("sub4",   16'h8001, 16'h0001, 16'h8000);
    apply("ovf",    16'h7BFF, 16'h7BFF, 16'h7C00);
    apply("ninf",   16'hFC00, 16'h3C00, 16'hFC00);
    apply("inf0",   16'h7C00, 16'h0000, 16'h7E00);
    apply("nan",    16'h7D00, 16'h3C00, 16'h7E00);
    apply("nzero",  16'h8000, 16'h3C00, 16'h8000);
    apply("submax", 16'h03FF, 16'h3C01, 16'h0400);
    apply("maxfin", 16'h7BFF, 16'h3C00, 16'h7BFF);

    // Reset overrides the in-flight product, then release.
    @(negedge clk);
    input1 = 16'h3C00;
    input2 = 16'h4000;
    rst_n  = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_hold", result, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_rel", result, 16'h4000);

    // Back-to-back vectors: a new operand pair every cycle.
    for (int i = 0; i < 3000; i++) begin
      a = rand_op();
      b = rand_op();
      apply(i < 10 ? "pipe" : "rand", a, b, ref_mul(a, b));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
